// File: rtl/rsa_sched_pkg.sv
// Shared types for the RSA job scheduler.
// State encoding and requester indices.
package rsa_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE,
    S_ABORT
  } sched_state_t;

  localparam int REQ_SPI  = 0;
  localparam int REQ_GPIO = 1;
  localparam int NUM_REQ  = 2;

endpackage

// File: rtl/rsa_rr_arbiter.sv
// Two-way round-robin pick for the RSA scheduler.
// On a tie the requester that did not go last wins.
module rsa_rr_arbiter
  import rsa_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] pick
);

  always_comb begin
    pick = '0;
    unique case (1'b1)
      (req == 2'b11): pick = last ? 2'b01 : 2'b10;
      (req == 2'b01): pick = 2'b01;
      (req == 2'b10): pick = 2'b10;
      default:        pick = '0;
    endcase
  end

endmodule

// File: rtl/rsa_job_scheduler.sv
// Shares one rsa_unit between SPI and GPIO requesters.
// Grants, latches operands, runs clear/run/capture.
module rsa_job_scheduler
  import rsa_sched_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TIMEOUT_W = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         stop,
  input  logic [NUM_REQ*WIDTH-1:0]   p_in,
  input  logic [NUM_REQ*WIDTH-1:0]   e_in,
  input  logic [NUM_REQ*WIDTH-1:0]   m_in,
  input  logic [NUM_REQ*WIDTH-1:0]   const_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         abort,
  output logic                       timeout,
  output logic [WIDTH-1:0]           result,
  output logic                       result_owner,
  output logic                       result_valid,
  output logic                       busy,
  output logic                       rsa_en,
  output logic                       rsa_clear,
  output logic [WIDTH-1:0]           rsa_p,
  output logic [WIDTH-1:0]           rsa_e,
  output logic [WIDTH-1:0]           rsa_m,
  output logic [WIDTH-1:0]           rsa_const,
  input  logic                       rsa_eoc,
  input  logic [WIDTH-1:0]           rsa_c
);

  localparam logic [TIMEOUT_W-1:0] TIMER_LAST =
    {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  sched_state_t         state_q, state_d;
  logic                 owner_q;
  logic                 last_q;
  logic                 tmo_q;
  logic [TIMEOUT_W-1:0] timer_q;
  logic [NUM_REQ-1:0]   pick;
  logic [NUM_REQ-1:0]   owner_oh;
  logic                 sel;
  logic                 do_grant;
  logic                 do_capture;
  logic                 do_abort;
  logic                 do_tmo;

  rsa_rr_arbiter u_arb (
    .req  (req),
    .last (last_q),
    .pick (pick)
  );

  assign sel = pick[REQ_GPIO];

  always_comb begin
    state_d    = state_q;
    do_grant   = 1'b0;
    do_capture = 1'b0;
    do_abort   = 1'b0;
    do_tmo     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          do_grant = 1'b1;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        // eoc outranks stop and the timer
        if (rsa_eoc) begin
          do_capture = 1'b1;
          state_d    = S_DONE;
        end else if (stop[owner_q]) begin
          do_abort = 1'b1;
          state_d  = S_ABORT;
        end else if (timer_q == TIMER_LAST) begin
          do_abort = 1'b1;
          do_tmo   = 1'b1;
          state_d  = S_ABORT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      tmo_q        <= 1'b0;
      timer_q      <= '0;
      result       <= '0;
      result_owner <= 1'b0;
      result_valid <= 1'b0;
      rsa_p        <= '0;
      rsa_e        <= '0;
      rsa_m        <= '0;
      rsa_const    <= '0;
    end else if (ena) begin
      state_q <= state_d;
      if (state_q == S_RUN)
        timer_q <= timer_q + 1'b1;
      if (do_grant) begin
        owner_q      <= sel;
        timer_q      <= '0;
        result_valid <= 1'b0;
        rsa_p     <= sel ? p_in[2*WIDTH-1:WIDTH]
                         : p_in[WIDTH-1:0];
        rsa_e     <= sel ? e_in[2*WIDTH-1:WIDTH]
                         : e_in[WIDTH-1:0];
        rsa_m     <= sel ? m_in[2*WIDTH-1:WIDTH]
                         : m_in[WIDTH-1:0];
        rsa_const <= sel ? const_in[2*WIDTH-1:WIDTH]
                         : const_in[WIDTH-1:0];
      end
      if (do_capture) begin
        result       <= rsa_c;
        result_owner <= owner_q;
        result_valid <= 1'b1;
      end
      if (do_capture || do_abort) begin
        last_q <= owner_q;
        tmo_q  <= do_tmo;
      end
    end
  end

  assign owner_oh  = owner_q ? 2'b10 : 2'b01;
  assign busy      = (state_q != S_IDLE);
  assign gnt       = busy ? owner_oh : '0;
  assign done      = (ena && state_q == S_DONE) ? owner_oh : '0;
  assign abort     = (ena && state_q == S_ABORT) ? owner_oh : '0;
  assign timeout   = ena && (state_q == S_ABORT) && tmo_q;
  assign rsa_en    = ena && (state_q == S_RUN);
  assign rsa_clear = (state_q == S_CLEAR) || (state_q == S_ABORT);

endmodule
